// File: rtl/conv_seq_if.sv
// Handshake bundle between conv_seq and its neighbours: layer start,
// weight store request, datapath issue/enable and the tagged result stream.
interface conv_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        wt_req;
  logic        wt_ack;
  logic [3:0]  wt_chan;
  logic [3:0]  win_row;
  logic [3:0]  win_col;
  logic        issue;
  logic        pipe_en;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic [3:0]  out_chan;
  logic [15:0] stall_cnt;

  modport master (
    input  start, wt_ack, out_ready,
    output busy, done, wt_req, wt_chan, win_row, win_col, issue, pipe_en,
           out_valid, out_row, out_col, out_chan, stall_cnt
  );

  modport slave (
    output start, wt_ack, out_ready,
    input  busy, done, wt_req, wt_chan, win_row, win_col, issue, pipe_en,
           out_valid, out_row, out_col, out_chan, stall_cnt
  );
endinterface

// File: rtl/conv_seq.sv
// 3x3 conv window/channel sequencer with a LAT-deep coordinate tag pipeline.
// Optional backpressure stall counter under CONV_SEQ_PERF_EN.
module conv_seq #(
  parameter int unsigned OUT_H = 14,
  parameter int unsigned OUT_W = 13,
  parameter int unsigned CHAN  = 10,
  parameter int unsigned LAT   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  conv_seq_if.master    bus
);

  localparam int unsigned CW  = 4;
  localparam int unsigned TGW = 3 * CW;
  localparam int unsigned TW  = LAT * TGW;
  localparam logic [CW-1:0]  LAST_ROW  = CW'(OUT_H - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(OUT_W - 1);
  localparam logic [CW-1:0]  LAST_CHAN = CW'(CHAN - 1);
  // Valid bits of every stage except the output stage.
  localparam logic [LAT-1:0] UP_MASK   = LAT'((1 << (LAT - 1)) - 1);

  typedef enum logic [2:0] {IDLE, WLOAD, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   chan_q, chan_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LAT-1:0]  valid_q, valid_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic            pipe_en_c;
  logic            issue_c;
  logic            out_valid_c;
  logic            upstream_c;

  assign out_valid_c = valid_q[LAT-1];
  assign upstream_c  = |(valid_q & UP_MASK);

  // Next-state, counters and datapath enable.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    row_d     = row_q;
    col_d     = col_q;
    pipe_en_c = 1'b0;
    issue_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = WLOAD;
          chan_d  = '0;
        end
      end
      WLOAD: begin
        if (bus.wt_ack) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      RUN: begin
        pipe_en_c = ~(out_valid_c & ~bus.out_ready);
        issue_c   = pipe_en_c;
        if (issue_c) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + CW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        pipe_en_c = ~(out_valid_c & ~bus.out_ready);
        // Pipeline empties on this edge: output stage drains, nothing behind it.
        if (pipe_en_c && !upstream_c) begin
          if (chan_q == LAST_CHAN) begin
            state_d = DONE;
          end else begin
            chan_d  = chan_q + CW'(1);
            state_d = WLOAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tag pipeline advances only with the datapath enable.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (pipe_en_c) begin
      valid_d = (valid_q << 1) | LAT'(issue_c);
      tag_d   = (tag_q << TGW) | TW'({row_q, col_q, chan_q});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      chan_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.wt_req    = (state_q == WLOAD);
  assign bus.wt_chan   = chan_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.issue     = issue_c;
  assign bus.pipe_en   = pipe_en_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_row   = tag_q[TW-1 -: CW];
  assign bus.out_col   = tag_q[TW-1-CW -: CW];
  assign bus.out_chan  = tag_q[TW-1-2*CW -: CW];

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of RUN/DRAIN cycles frozen by backpressure.
  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start) begin
      stall_d = '0;
    end else if ((state_q == RUN || state_q == DRAIN) && !pipe_en_c &&
                 stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_conv_seq.sv
// Scoreboard bench for conv_seq: expected beats come from a raster model,
// a negedge monitor pops and compares on every accepted result.
module tb_conv_seq;

  localparam int OH = 14;
  localparam int OW = 13;
  localparam int NC = 10;
  localparam int NB = OH * OW * NC;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_seq_if bus();

  conv_seq #(.OUT_H(OH), .OUT_W(OW), .CHAN(NC), .LAT(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Stimulus controls
  int  cyc = 0;
  int  a = 0;
  bit  armed = 0;
  bit  init_rst = 1;
  bit  spur_start = 0;
  bit  ready_mode = 0;
  bit  ack_rand = 0;
  int  ack_dly = 0;
  int  stall_at = -100;
  int  stall_len = 0;
  int  reset_at = -100;
  int  req_run = 0;

  // Scoreboard state
  logic [11:0] exp_q[$];
  int  beats = 0;
  int  exp_wchan = 0;
  int  exp_req_len = 0;
  int  req_len = 0;
  int  done_cnt = 0;
  int  wl1 = -1;
  bit  prev_stall = 0;
  logic [11:0] prev_tag = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Input drivers, updated just after each active edge.
  always @(posedge clk) begin
    int cur;
    #1;
    cur = cyc - a;
    bus.start = armed && (cur == 0 || (spur_start && (cur == 300 || cur == 1851)));
    rst_n = !(init_rst || (armed && cur == reset_at));
    if (ready_mode) bus.out_ready = ($urandom_range(0, 3) != 0);
    else bus.out_ready = !(armed && cur >= stall_at && cur < stall_at + stall_len);
    if (bus.wt_req) req_run++;
    else req_run = 0;
    if (ack_rand) bus.wt_ack = ($urandom_range(0, 2) == 0);
    else bus.wt_ack = bus.wt_req && (req_run > ack_dly);
  end

  // Monitor
  always @(negedge clk) begin
    int cur;
    logic [11:0] e;
    cur = cyc - a;
    if (armed && reset_at >= 0 && cur == reset_at + 1) begin
      chk("reset_abort_outputs",
          {bus.busy, bus.done, bus.wt_req, bus.issue, bus.pipe_en, bus.out_valid,
           bus.wt_chan, bus.win_row, bus.win_col, bus.out_row, bus.out_col,
           bus.out_chan, bus.stall_cnt}, 64'd0);
      exp_q.delete();
    end
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", {bus.out_row, bus.out_col, bus.out_chan}, 64'hFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("beat_tag", {bus.out_row, bus.out_col, bus.out_chan}, e);
        beats <= beats + 1;
      end
    end
    if (prev_stall)
      chk("hold_stable", {bus.out_valid, bus.out_row, bus.out_col, bus.out_chan},
          {1'b1, prev_tag});
    if (rst_n && bus.out_valid && !bus.out_ready)
      chk("stall_freeze", {bus.pipe_en, bus.issue}, 2'b00);
    if (rst_n && bus.wt_req && req_len == 0) begin
      chk("wt_chan", bus.wt_chan, exp_wchan);
      chk("wload_no_issue", {bus.issue, bus.pipe_en}, 2'b00);
      if (exp_wchan == 1) wl1 <= cur;
      exp_wchan <= exp_wchan + 1;
    end
    if (bus.wt_req) begin
      req_len <= req_len + 1;
    end else if (req_len != 0) begin
      if (exp_req_len > 0) chk("wt_req_len", req_len, exp_req_len);
      req_len <= 0;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    prev_stall <= rst_n && bus.out_valid && !bus.out_ready;
    prev_tag   <= {bus.out_row, bus.out_col, bus.out_chan};
  end

  // Reference: raster order (row, col) within each channel, channels ascending.
  function automatic void load_expected();
    exp_q.delete();
    for (int ch = 0; ch < NC; ch++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          exp_q.push_back({4'(r), 4'(c), 4'(ch)});
  endfunction

  task automatic arm();
    @(posedge clk);
    #2;
    a = cyc + 1;
    armed = 1;
  endtask

  task automatic run_layer(input int dly, input int s_at, input int s_len,
                           input int exp_done, input int exp_stall, input int exp_wl1);
    int dc;
    int d0;
    int es;
    bit got;
    load_expected();
    beats = 0;
    exp_wchan = 0;
    wl1 = -1;
    ack_dly = dly;
    exp_req_len = ack_rand ? 0 : dly + 1;
    stall_at = s_at;
    stall_len = s_len;
    d0 = done_cnt;
    arm();
    got = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    dc = cyc - a;
    chk("done_seen", got, 1);
    if (exp_done >= 0) chk("done_cycle", dc, exp_done);
`ifdef CONV_SEQ_PERF_EN
    es = exp_stall;
`else
    es = 0;
`endif
    if (exp_stall >= 0) chk("stall_cnt", bus.stall_cnt, es);
    chk("beat_count", beats, NB);
    chk("queue_left", exp_q.size(), 0);
    chk("wload_count", exp_wchan, NC);
    if (exp_wl1 >= 0) chk("wload_ch1_cycle", wl1, exp_wl1);
    @(negedge clk);
    chk("after_done", {bus.busy, bus.done}, 2'b00);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    armed = 0;
  endtask

  task automatic run_abort(input int r_at);
    int d0;
    load_expected();
    beats = 0;
    exp_wchan = 0;
    ack_dly = 0;
    exp_req_len = 1;
    stall_at = -100;
    stall_len = 0;
    reset_at = r_at;
    d0 = done_cnt;
    arm();
    for (int i = 0; i < r_at + 10; i++) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", {bus.busy, bus.out_valid}, 2'b00);
    chk("abort_wloads", exp_wchan, 3);
    armed = 0;
    reset_at = -100;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.wt_ack = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {bus.busy, bus.done, bus.wt_req, bus.issue, bus.pipe_en, bus.out_valid,
         bus.wt_chan, bus.win_row, bus.win_col, bus.out_row, bus.out_col,
         bus.out_chan, bus.stall_cnt}, 64'd0);
    init_rst = 0;
    repeat (2) @(negedge clk);

    run_layer(0, -100, 0, 1851, 0, 186);   // baseline
    run_layer(5, -100, 0, 1901, 0, 191);   // slow weight store
    run_layer(0, 600, 7, 1858, 7, 186);    // backpressure mid-RUN of channel 3
    run_layer(0, 185, 3, 1854, 3, 189);    // last beat of channel 0 held
    run_abort(450);                        // reset during channel 2
    run_layer(0, -100, 0, 1851, 0, 186);   // restart from channel 0
    spur_start = 1;
    run_layer(0, -100, 0, 1851, 0, 186);   // starts during RUN and DONE
    spur_start = 0;
    ack_rand = 1;
    ready_mode = 1;
    run_layer(0, -100, 0, -1, -1, -1);
    run_layer(0, -100, 0, -1, -1, -1);
    ack_rand = 0;
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
